// File: rtl/lights_pkg.sv
// Shared definitions for the LED pixel stream capture path.
package lights_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SYNC,
    ST_RECV,
    ST_FLUSH,
    ST_DONE
  } cap_state_e;

  // Status word bit positions on the port bus
  localparam int unsigned STAT_BUSY    = 31;
  localparam int unsigned STAT_DONE    = 30;
  localparam int unsigned STAT_OVERRUN = 29;
  localparam int unsigned STAT_TRUNC   = 28;
  localparam int unsigned CTRL_ARM     = 31;

  // Bit timings shared with lights_controller (clk cycles)
  localparam int unsigned T1H_CYCLES  = 6;
  localparam int unsigned T0H_CYCLES  = 3;
  localparam int unsigned TBIT_CYCLES = 10;

  localparam int unsigned DEF_BIT_THRESH = 5;
  localparam int unsigned DEF_GAP_CYCLES = 64;
  localparam int unsigned DEF_MAX_BYTES  = 300;

  // High-pulse width counter saturates here
  localparam logic [4:0] WIDTH_SAT = 5'd31;

endpackage

// File: rtl/lights_bit_decoder.sv
// Synchronises din, measures high-pulse widths and detects inter-frame gaps.
module lights_bit_decoder
  import lights_pkg::*;
#(
  parameter int unsigned BIT_THRESH = DEF_BIT_THRESH,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic clr,
  output logic pulse_start,
  output logic bit_valid,
  output logic bit_value,
  output logic gap_seen
);

  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  logic          sync1_q, sync2_q, prev_q;
  logic [4:0]    width_q, width_d;
  logic [GW-1:0] low_q, low_d;
  logic          rise, fall;

  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;

  // Width counter restarts on each rising edge; low counter restarts on any high or clr
  always_comb begin
    width_d = width_q;
    if (rise) begin
      width_d = 5'd1;
    end else if (sync2_q && (width_q != WIDTH_SAT)) begin
      width_d = width_q + 5'd1;
    end
    low_d = low_q;
    if (clr || sync2_q) begin
      low_d = '0;
    end else if (low_q != GW'(GAP_CYCLES)) begin
      low_d = low_q + GW'(1);
    end
  end

  // Synchroniser, edge history and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      width_q <= '0;
      low_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      width_q <= width_d;
      low_q   <= low_d;
    end
  end

  assign pulse_start = rise;
  assign bit_valid   = fall;
  assign bit_value   = (width_q >= 5'(BIT_THRESH));
  assign gap_seen    = (low_q == GW'(GAP_CYCLES));

endmodule

// File: rtl/lights_capture.sv
// Captures a pulse-width LED stream into memory as packed 16-bit words.
module lights_capture
  import lights_pkg::*;
#(
  parameter logic [7:0]  PORT_ADDR  = 8'd2,
  parameter int unsigned BIT_THRESH = DEF_BIT_THRESH,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int unsigned MAX_BYTES  = DEF_MAX_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic [17:0] m_a_adr,
  output logic        m_a_req,
  input  logic        m_a_ack,
  output logic        m_a_write,
  output logic [1:0]  m_a_sel,
  input  logic [15:0] m_a_rdata,
  output logic [15:0] m_a_wdata,
  input  logic [7:0]  port_addr,
  input  logic        port_req,
  output logic        port_ack,
  output logic [31:0] port_rdata,
  input  logic [31:0] port_wdata
);

  cap_state_e  state_q, state_d;
  logic [17:0] base_q, base_d;
  logic [8:0]  count_q, count_d;
  logic [7:0]  lo_q, lo_d;
  logic        lo_pend_q, lo_pend_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  nbits_q, nbits_d;
  logic        done_q, done_d;
  logic        overrun_q, overrun_d;
  logic        trunc_q, trunc_d;
  logic        req_q, req_d;
  logic [17:0] adr_q, adr_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] wdata_q, wdata_d;
  logic        ack_q;

  logic        port_sel, arm, busy;
  logic        pulse_start, bit_valid, bit_value, gap_seen;
  logic [7:0]  byte_val;
  logic [17:0] word_adr;
  logic        hold_free;
  logic        unused_bits;

  assign unused_bits = ^{m_a_rdata, port_wdata[30:19], port_wdata[0]};

  assign port_sel  = (port_addr == PORT_ADDR);
  assign arm       = port_sel & port_req & port_wdata[CTRL_ARM];
  assign byte_val  = {shift_q[6:0], bit_value};
  assign word_adr  = base_q + {10'd0, count_q[8:1]};
  assign hold_free = ~req_q | m_a_ack;

  lights_bit_decoder #(
    .BIT_THRESH (BIT_THRESH),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_dec (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .clr         (arm),
    .pulse_start (pulse_start),
    .bit_valid   (bit_valid),
    .bit_value   (bit_value),
    .gap_seen    (gap_seen)
  );

  // Next-state: frame FSM, byte packing and single-entry write holding register
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    lo_d      = lo_q;
    lo_pend_d = lo_pend_q;
    shift_d   = shift_q;
    nbits_d   = nbits_q;
    done_d    = done_q;
    overrun_d = overrun_q;
    trunc_d   = trunc_q;
    req_d     = req_q;
    adr_d     = adr_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;

    if (m_a_ack) begin
      req_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: ;
      ST_ARMED: begin
        if (gap_seen) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (pulse_start) begin
          state_d = ST_RECV;
          nbits_d = '0;
          shift_d = '0;
        end
      end
      ST_RECV: begin
        // Byte handling precedes the gap check so a coincident final byte is kept
        if (bit_valid) begin
          shift_d = byte_val;
          nbits_d = nbits_q + 3'd1;
          if (nbits_q == 3'd7) begin
            if (count_q == 9'(MAX_BYTES)) begin
              trunc_d = 1'b1;
            end else begin
              count_d = count_q + 9'd1;
              if (!count_q[0]) begin
                lo_d      = byte_val;
                lo_pend_d = 1'b1;
              end else begin
                lo_pend_d = 1'b0;
                if (hold_free) begin
                  req_d   = 1'b1;
                  adr_d   = word_adr;
                  wdata_d = {byte_val, lo_q};
                  sel_d   = 2'b11;
                end else begin
                  overrun_d = 1'b1;
                end
              end
            end
          end
        end
        if (gap_seen) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (lo_pend_q) begin
          if (hold_free) begin
            req_d     = 1'b1;
            adr_d     = word_adr;
            wdata_d   = {8'h00, lo_q};
            sel_d     = 2'b01;
            lo_pend_d = 1'b0;
          end
        end else if (!req_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Arming wins over everything and abandons any frame in progress
    if (arm) begin
      state_d   = ST_ARMED;
      base_d    = port_wdata[18:1];
      count_d   = '0;
      lo_pend_d = 1'b0;
      shift_d   = '0;
      nbits_d   = '0;
      done_d    = 1'b0;
      overrun_d = 1'b0;
      trunc_d   = 1'b0;
      req_d     = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      count_q   <= '0;
      lo_q      <= '0;
      lo_pend_q <= 1'b0;
      shift_q   <= '0;
      nbits_q   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      trunc_q   <= 1'b0;
      req_q     <= 1'b0;
      adr_q     <= '0;
      sel_q     <= 2'b11;
      wdata_q   <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      lo_q      <= lo_d;
      lo_pend_q <= lo_pend_d;
      shift_q   <= shift_d;
      nbits_q   <= nbits_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      trunc_q   <= trunc_d;
      req_q     <= req_d;
      adr_q     <= adr_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      ack_q     <= port_sel & port_req;
    end
  end

  assign busy = (state_q == ST_ARMED) || (state_q == ST_SYNC) ||
                (state_q == ST_RECV)  || (state_q == ST_FLUSH);

  assign m_a_adr   = adr_q;
  assign m_a_req   = req_q;
  assign m_a_write = 1'b1;
  assign m_a_sel   = sel_q;
  assign m_a_wdata = wdata_q;

  assign port_ack   = port_sel ? ack_q : 1'bz;
  assign port_rdata = port_sel ? {busy, done_q, overrun_q, trunc_q, 19'd0, count_q} : 'z;

endmodule

// File: tb/tb_lights_capture.sv
// Self-checking bench for lights_capture: vector table, directed corners, random frames.
module tb_lights_capture;
  import lights_pkg::*;

  typedef logic [35:0] wr_t;  // {adr[17:0], data[15:0], sel[1:0]}
  typedef struct {
    logic [7:0]  pattern;
    int unsigned w0;
    int unsigned w1;
    logic [7:0]  expb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic [17:0] m_a_adr;
  logic        m_a_req, m_a_ack, m_a_write;
  logic [1:0]  m_a_sel;
  logic [15:0] m_a_rdata, m_a_wdata;
  logic [7:0]  port_addr = 8'd2;
  logic        port_req = 1'b0;
  logic [31:0] port_wdata = '0;
  wire         port_ack;
  wire  [31:0] port_rdata;

  logic hold_ack = 1'b0;
  logic rnd_mode = 1'b0;
  logic rnd_ack  = 1'b1;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  wr_t wq[$];

  always #5 clk = ~clk;

  assign m_a_ack   = m_a_req & ~hold_ack & rnd_ack;
  assign m_a_rdata = 16'h0;

  lights_capture #(
    .PORT_ADDR  (8'd2),
    .BIT_THRESH (5),
    .GAP_CYCLES (64),
    .MAX_BYTES  (300)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .m_a_adr    (m_a_adr),
    .m_a_req    (m_a_req),
    .m_a_ack    (m_a_ack),
    .m_a_write  (m_a_write),
    .m_a_sel    (m_a_sel),
    .m_a_rdata  (m_a_rdata),
    .m_a_wdata  (m_a_wdata),
    .port_addr  (port_addr),
    .port_req   (port_req),
    .port_ack   (port_ack),
    .port_rdata (port_rdata),
    .port_wdata (port_wdata)
  );

  // Memory slave: log every accepted write
  always @(negedge clk) begin
    if (m_a_req && m_a_ack) wq.push_back({m_a_adr, m_a_wdata, m_a_sel});
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_ack = rnd_mode ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int unsigned hi, input int unsigned lo);
    din = 1'b1;
    tick(hi);
    din = 1'b0;
    tick(lo);
  endtask

  // w*/lo ranges inclusive; lo_max==0 means fill the remainder of a TX bit period
  task automatic send_byte_r(input logic [7:0] b, input int unsigned w0a, input int unsigned w0b,
                             input int unsigned w1a, input int unsigned w1b,
                             input int unsigned lo_min, input int unsigned lo_max);
    int unsigned h, l;
    for (int i = 7; i >= 0; i--) begin
      h = b[i] ? $urandom_range(w1b, w1a) : $urandom_range(w0b, w0a);
      if (lo_max == 0) l = (h < TBIT_CYCLES) ? TBIT_CYCLES - h : 4;
      else l = $urandom_range(lo_max, lo_min);
      pulse(h, l);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_byte_r(b, T0H_CYCLES, T0H_CYCLES, T1H_CYCLES, T1H_CYCLES, 0, 0);
  endtask

  task automatic gap();
    din = 1'b0;
    tick(80);
  endtask

  task automatic port_write(input logic [31:0] wd);
    port_req   = 1'b1;
    port_wdata = wd;
    tick(1);
    port_req   = 1'b0;
    port_wdata = '0;
    chk("port_ack_next", 64'(port_ack), 64'd1);
    tick(1);
    chk("port_ack_single", 64'(port_ack), 64'd0);
  endtask

  task automatic arm(input logic [17:0] base);
    port_write({1'b1, 12'd0, base, 1'b0});
  endtask

  task automatic wait_idle();
    int unsigned k = 0;
    while (port_rdata[31] && k < 400) begin
      tick(1);
      k++;
    end
    chk("idle_timeout", 64'(port_rdata[31]), 64'd0);
  endtask

  function automatic logic [31:0] stat(input logic busy, input logic done, input logic ov,
                                       input logic tr, input int unsigned cnt);
    return {busy, done, ov, tr, 19'd0, 9'(cnt)};
  endfunction

  task automatic chk_wr(input string name, input int unsigned idx, input logic [17:0] adr,
                        input logic [15:0] data, input logic [1:0] sel);
    wr_t act;
    act = (idx < wq.size()) ? wq[idx] : '1;
    chk(name, 64'(act), 64'({adr, data, sel}));
  endtask

  // Reference model: bytes pair up little-endian into words at base+i; odd tail goes low lane only
  task automatic expect_frame(input logic [17:0] base, input logic [7:0] b[$], input string tag);
    int unsigned kept;
    wr_t exp_q[$];
    wr_t act;
    kept = (b.size() > 300) ? 300 : b.size();
    for (int unsigned i = 0; i + 1 < kept; i += 2)
      exp_q.push_back({base + 18'(i / 2), b[i + 1], b[i], 2'b11});
    if (kept % 2 == 1)
      exp_q.push_back({base + 18'(kept / 2), 8'h00, b[kept - 1], 2'b01});
    chk($sformatf("%s_nwrites", tag), 64'(wq.size()), 64'(exp_q.size()));
    for (int unsigned i = 0; i < exp_q.size(); i++) begin
      act = (i < wq.size()) ? wq[i] : '1;
      chk($sformatf("%s_wr%0d", tag, i), 64'(act), 64'(exp_q[i]));
    end
    chk($sformatf("%s_status", tag), 64'(port_rdata),
        64'(stat(1'b0, 1'b1, 1'b0, b.size() > 300, kept)));
    wq.delete();
  endtask

  initial begin
    vec_t vt[6];
    logic [7:0]  bq[$];
    logic [17:0] base;
    int unsigned n;

    vt[0] = '{8'hA5, 3, 6, 8'hA5};
    vt[1] = '{8'hFF, 4, 4, 8'h00};
    vt[2] = '{8'hFF, 5, 5, 8'hFF};
    vt[3] = '{8'h96, 4, 5, 8'h96};
    vt[4] = '{8'hC3, 1, 40, 8'hC3};
    vt[5] = '{8'h00, 3, 6, 8'h00};

    tick(4);
    rst = 1'b0;
    tick(1);

    chk("rst_req", 64'(m_a_req), 64'd0);
    chk("rst_adr", 64'(m_a_adr), 64'd0);
    chk("rst_sel", 64'(m_a_sel), 64'd3);
    chk("rst_wdata", 64'(m_a_wdata), 64'd0);
    chk("rst_write", 64'(m_a_write), 64'd1);
    chk("rst_port_ack", 64'(port_ack), 64'd0);
    chk("rst_status", 64'(port_rdata), 64'd0);

    // Four bytes at TX timing into base 0x400
    port_write(32'h8000_0800);
    chk("armed_busy", 64'(port_rdata), 64'(stat(1'b1, 1'b0, 1'b0, 1'b0, 0)));
    gap();
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    gap();
    wait_idle();
    chk("t1_nwrites", 64'(wq.size()), 64'd2);
    chk_wr("t1_wr0", 0, 18'h400, 16'h3412, 2'b11);
    chk_wr("t1_wr1", 1, 18'h401, 16'h7856, 2'b11);
    chk("t1_status", 64'(port_rdata), 64'h4000_0004);
    wq.delete();

    // Access to another address must not arm
    port_addr = 8'd3; port_req = 1'b1; port_wdata = 32'h8000_0000;
    tick(1);
    port_req = 1'b0; port_wdata = '0; port_addr = 8'd2;
    tick(1);
    chk("unsel_no_arm", 64'(port_rdata), 64'h4000_0004);

    // Odd byte count: partial final word
    arm(18'h0A0);
    gap();
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    gap();
    wait_idle();
    chk("t2_nwrites", 64'(wq.size()), 64'd2);
    chk_wr("t2_wr0", 0, 18'h0A0, 16'hBBAA, 2'b11);
    chk_wr("t2_wr1", 1, 18'h0A1, 16'h00CC, 2'b01);
    chk("t2_status", 64'(port_rdata), 64'h4000_0003);
    wq.delete();

    // Pulse-width decoding table: one byte per frame
    for (int i = 0; i < 6; i++) begin
      base = 18'h100 + 18'(i * 16);
      arm(base);
      gap();
      send_byte_r(vt[i].pattern, vt[i].w0, vt[i].w0, vt[i].w1, vt[i].w1, 0, 0);
      gap();
      wait_idle();
      chk($sformatf("vec%0d_nwrites", i), 64'(wq.size()), 64'd1);
      chk_wr($sformatf("vec%0d_wr", i), 0, base, {8'h00, vt[i].expb}, 2'b01);
      wq.delete();
    end

    // Address wrap at the top of the 18-bit space
    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    arm(18'h3FFFF);
    gap();
    foreach (bq[i]) send_byte(bq[i]);
    gap();
    wait_idle();
    expect_frame(18'h3FFFF, bq, "wrap");

    // Truncation: 302 bytes, only 300 stored
    bq.delete();
    for (int i = 0; i < 302; i++) bq.push_back(8'(i * 7 + 3));
    arm(18'h1000);
    gap();
    foreach (bq[i]) send_byte(bq[i]);
    gap();
    wait_idle();
    chk("trunc_last_adr", 64'(wq.size() > 0 ? wq[wq.size() - 1][35:18] : '1), 64'(18'h1000 + 18'd149));
    expect_frame(18'h1000, bq, "trunc");

    // Overrun: second word completes while first is still unacknowledged
    hold_ack = 1'b1;
    arm(18'h200);
    gap();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    chk("ovr_req_held", 64'(m_a_req), 64'd1);
    chk("ovr_flag_busy", 64'(port_rdata[31:28]), 64'hA);
    hold_ack = 1'b0;
    send_byte(8'h55); send_byte(8'h66);
    gap();
    wait_idle();
    chk("ovr_nwrites", 64'(wq.size()), 64'd2);
    chk_wr("ovr_wr0", 0, 18'h200, 16'h2211, 2'b11);
    chk_wr("ovr_wr1", 1, 18'h202, 16'h6655, 2'b11);
    chk("ovr_status", 64'(port_rdata), 64'h6000_0006);
    wq.delete();

    // Randomised frames against the reference model, with random ack stalls
    rnd_mode = 1'b1;
    for (int f = 0; f < 6; f++) begin
      base = 18'($urandom);
      n = $urandom_range(10, 1);
      bq.delete();
      for (int unsigned i = 0; i < n; i++) bq.push_back(8'($urandom));
      arm(base);
      gap();
      foreach (bq[i]) send_byte_r(bq[i], 1, 4, 5, 35, 2, 9);
      gap();
      wait_idle();
      expect_frame(base, bq, $sformatf("rand%0d", f));
    end
    rnd_mode = 1'b0;
    tick(2);

    // Reset in the middle of a frame with a write pending
    hold_ack = 1'b1;
    arm(18'h300);
    gap();
    send_byte(8'hAB); send_byte(8'hCD);
    pulse(6, 4); pulse(3, 7); pulse(6, 4); pulse(3, 7);
    chk("mrst_req_before", 64'(m_a_req), 64'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mrst_req_after", 64'(m_a_req), 64'd0);
    chk("mrst_status", 64'(port_rdata), 64'd0);
    hold_ack = 1'b0;
    pulse(6, 4); pulse(3, 7); pulse(6, 4); pulse(3, 7);
    send_byte(8'hEF); send_byte(8'h01);
    gap();
    tick(100);
    chk("mrst_no_writes", 64'(wq.size()), 64'd0);
    chk("mrst_status_idle", 64'(port_rdata), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
